// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//
// Sequences a chain of NUM_LAYERS dense layers. For every neuron it requests
// bias + weights from the DMA engine, steers the shared bus into the ALU and
// strobes the result into that layer's neuron buffer. Weight blocks are
// packed back-to-back: base(l+1) = base(l) + OUT(l)*(IN(l)+1), computed at
// elaboration and wrapped to MEM_ADDRESS_WIDTH.
//
// All outputs are registered: the values assigned while in a state become
// visible on the enabled edge that leaves (or re-evaluates) that state.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-low reset (overrides clk_en)
//   clk_en         advance enable; when low every register holds
//   start          CNN output ready; level in IDLE, rising edge in DONE
//   DMA_read       DMA request active
//   DMA_address    start address of the requested block
//   DMA_count      words requested (1 bias + IN weights)
//   DMA_ready      requested block is on the bus (only honoured in WAIT_DMA)
//   ALU_clear      clear accumulators
//   ALU_en         ALU consume strobe
//   ALU_load       0 = values, 1 = bias/weights, 2 = idle
//   Neuron_en      buffer write select, l = layer l, all-ones = none
//   Neuron_address neuron index being written
//   Bus_datasrc    0 = CNN buffer, l+1 = layer l buffer, all-ones = DMA
//   layer          current layer index
//   done           all layers complete
//   abort          (FC_ABORT_EN only) return to IDLE from any active state
//
// Build option: define FC_ABORT_EN to add the abort port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | set up the layer's DMA base, input source and clear counter
// WAIT_DMA | waiting for the current neuron's bias+weights block
// ACCUM    | ALU consumes the block
// WRITE    | strobe the result into the layer buffer
// NEXT     | layer finished, advance layer or finish
// DONE     | all layers written, waiting for a fresh start edge

module fc_layer_sequencer #(
    parameter int MEM_ADDRESS_WIDTH   = 16,
    parameter int LAYER_ADDRESS_WIDTH = 7,
    parameter int NUM_LAYERS          = 2,
    parameter logic [NUM_LAYERS*LAYER_ADDRESS_WIDTH-1:0] IN_SIZES  = {7'd84, 7'd120},
    parameter logic [NUM_LAYERS*LAYER_ADDRESS_WIDTH-1:0] OUT_SIZES = {7'd10, 7'd84},
    parameter logic [MEM_ADDRESS_WIDTH-1:0] WEIGHT_BASE = '0,
    localparam int S = $clog2(NUM_LAYERS + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic                           start,
    output logic                           DMA_read,
    output logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address,
    output logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count,
    input  logic                           DMA_ready,
    output logic                           ALU_clear,
    output logic                           ALU_en,
    output logic [1:0]                     ALU_load,
    output logic [S-1:0]                   Neuron_en,
    output logic [LAYER_ADDRESS_WIDTH-1:0] Neuron_address,
    output logic [S-1:0]                   Bus_datasrc,
    output logic [2:0]                     layer,
`ifdef FC_ABORT_EN
    input  logic                           abort,
`endif
    output logic                           done
);

    localparam int MAW = MEM_ADDRESS_WIDTH;
    localparam int LAW = LAYER_ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_DMA, ACCUM, WRITE, NEXT, DONE
    } state_t;

    function automatic logic [NUM_LAYERS*MAW-1:0] calc_bases();
        logic [NUM_LAYERS*MAW-1:0] r;
        logic [MAW-1:0]            b;
        r = '0;
        b = WEIGHT_BASE;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            r[i*MAW +: MAW] = b;
            b = b + MAW'(32'(OUT_SIZES[i*LAW +: LAW]) * (32'(IN_SIZES[i*LAW +: LAW]) + 32'd1));
        end
        return r;
    endfunction

    localparam logic [NUM_LAYERS*MAW-1:0] BASES = calc_bases();

    // Per-layer lookups as explicit muxes over the packed parameters.
    function automatic logic [LAW-1:0] in_of(input logic [2:0] l);
        logic [LAW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (l == 3'(i)) v = IN_SIZES[i*LAW +: LAW];
        return v;
    endfunction

    function automatic logic [LAW-1:0] out_of(input logic [2:0] l);
        logic [LAW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (l == 3'(i)) v = OUT_SIZES[i*LAW +: LAW];
        return v;
    endfunction

    function automatic logic [MAW-1:0] base_of(input logic [2:0] l);
        logic [MAW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (l == 3'(i)) v = BASES[i*MAW +: MAW];
        return v;
    endfunction

    state_t         state_q, state_d;
    logic [LAW-1:0] cnt_q, cnt_d;
    logic           start_q;

    logic           dma_read_d, alu_clear_d, alu_en_d, done_d;
    logic [MAW-1:0] dma_address_d;
    logic [LAW-1:0] dma_count_d, neuron_address_d;
    logic [1:0]     alu_load_d;
    logic [S-1:0]   neuron_en_d, bus_datasrc_d;
    logic [2:0]     layer_d;

    logic [LAW-1:0] in_cur, out_cur;
    logic [MAW-1:0] base_cur;
    logic           last_neuron, last_layer;

    always_comb begin
        in_cur      = in_of(layer);
        out_cur     = out_of(layer);
        base_cur    = base_of(layer);
        last_neuron = (cnt_q == out_cur - LAW'(1));
        last_layer  = (layer == 3'(NUM_LAYERS - 1));
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        dma_read_d       = DMA_read;
        dma_address_d    = DMA_address;
        dma_count_d      = DMA_count;
        alu_clear_d      = ALU_clear;
        alu_en_d         = ALU_en;
        alu_load_d       = ALU_load;
        neuron_en_d      = Neuron_en;
        neuron_address_d = Neuron_address;
        bus_datasrc_d    = Bus_datasrc;
        layer_d          = layer;
        done_d           = done;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    layer_d = '0;
                end
            end
            LOAD: begin
                alu_clear_d   = 1'b0;
                alu_load_d    = 2'd0;
                bus_datasrc_d = S'(layer);
                dma_read_d    = 1'b1;
                dma_address_d = base_cur;
                dma_count_d   = in_cur + LAW'(1);
                cnt_d         = '0;
                state_d       = WAIT_DMA;
            end
            WAIT_DMA: begin
                // Ends the single-cycle write strobe raised on the WRITE edge.
                neuron_en_d = '1;
                if (DMA_ready) begin
                    alu_en_d         = 1'b1;
                    alu_load_d       = 2'd1;
                    bus_datasrc_d    = '1;
                    neuron_address_d = cnt_q;
                    dma_address_d    = DMA_address + MAW'(in_cur) + MAW'(1);
                    if (last_neuron) dma_read_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                alu_en_d   = 1'b0;
                alu_load_d = 2'd2;
                state_d    = WRITE;
            end
            WRITE: begin
                neuron_en_d = S'(layer);
                if (last_neuron) begin
                    state_d = NEXT;
                end else begin
                    cnt_d   = cnt_q + LAW'(1);
                    state_d = WAIT_DMA;
                end
            end
            NEXT: begin
                alu_clear_d = 1'b1;
                neuron_en_d = '1;
                if (last_layer) begin
                    done_d        = 1'b1;
                    bus_datasrc_d = S'(NUM_LAYERS);
                    state_d       = DONE;
                end else begin
                    layer_d = layer + 3'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                // Only a fresh rising edge restarts; a held start keeps DONE.
                if (start && !start_q) begin
                    done_d  = 1'b0;
                    layer_d = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FC_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d          = IDLE;
            cnt_d            = '0;
            dma_read_d       = 1'b0;
            dma_address_d    = '0;
            dma_count_d      = '0;
            alu_clear_d      = 1'b1;
            alu_en_d         = 1'b0;
            alu_load_d       = 2'd2;
            neuron_en_d      = '1;
            neuron_address_d = '0;
            bus_datasrc_d    = '0;
            layer_d          = '0;
            done_d           = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            start_q        <= 1'b0;
            DMA_read       <= 1'b0;
            DMA_address    <= '0;
            DMA_count      <= '0;
            ALU_clear      <= 1'b1;
            ALU_en         <= 1'b0;
            ALU_load       <= 2'd2;
            Neuron_en      <= '1;
            Neuron_address <= '0;
            Bus_datasrc    <= '0;
            layer          <= '0;
            done           <= 1'b0;
        end else if (clk_en) begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            start_q        <= start;
            DMA_read       <= dma_read_d;
            DMA_address    <= dma_address_d;
            DMA_count      <= dma_count_d;
            ALU_clear      <= alu_clear_d;
            ALU_en         <= alu_en_d;
            ALU_load       <= alu_load_d;
            Neuron_en      <= neuron_en_d;
            Neuron_address <= neuron_address_d;
            Bus_datasrc    <= bus_datasrc_d;
            layer          <= layer_d;
            done           <= done_d;
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer (default parameters). Define FC_ABORT_EN
// to also exercise the abort port.
module tb_fc_layer_sequencer;

    localparam int NL = 2;
    localparam int IN_T [NL]  = '{120, 84};
    localparam int OUT_T [NL] = '{84, 10};
    localparam logic [42:0] RST_VALS =
        {1'b0, 16'd0, 7'd0, 1'b1, 1'b0, 2'd2, 2'b11, 7'd0, 2'd0, 3'd0, 1'b0};

    logic        clk = 1'b0;
    logic        rst, clk_en, start, DMA_ready;
`ifdef FC_ABORT_EN
    logic        abort;
`endif
    logic        DMA_read, ALU_clear, ALU_en, done;
    logic [15:0] DMA_address;
    logic [6:0]  DMA_count, Neuron_address;
    logic [1:0]  ALU_load, Neuron_en, Bus_datasrc;
    logic [2:0]  layer;
    logic [42:0] outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_layer_sequencer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
        .DMA_read(DMA_read), .DMA_address(DMA_address), .DMA_count(DMA_count),
        .DMA_ready(DMA_ready), .ALU_clear(ALU_clear), .ALU_en(ALU_en),
        .ALU_load(ALU_load), .Neuron_en(Neuron_en), .Neuron_address(Neuron_address),
        .Bus_datasrc(Bus_datasrc), .layer(layer),
`ifdef FC_ABORT_EN
        .abort(abort),
`endif
        .done(done)
    );

    assign outs = {DMA_read, DMA_address, DMA_count, ALU_clear, ALU_en, ALU_load,
                   Neuron_en, Neuron_address, Bus_datasrc, layer, done};

    // Monitor: one record per write strobe and per accepted DMA block,
    // counted only on enabled edges.
    logic        en_edge = 1'b0;
    logic [15:0] p_addr = '0;
    logic [6:0]  p_cnt = '0;
    logic        p_read = 1'b0, p_alu_en = 1'b0;
    int          cyc = 0;
    logic [31:0] obs_wr[$], obs_fa[$], exp_wr[$], exp_fa[$];
    int          obs_wc[$];

    always @(posedge clk) en_edge = clk_en && rst;

    always @(negedge clk) begin
        if (en_edge) begin
            cyc++;
            if (Neuron_en != 2'b11) begin
                obs_wr.push_back({20'd0, Neuron_en, layer, Neuron_address});
                obs_wc.push_back(cyc);
            end
            if (ALU_en && !p_alu_en)
                obs_fa.push_back({3'd0, p_addr, p_cnt, p_read, DMA_read, Bus_datasrc, ALU_load});
        end
        p_addr   = DMA_address;
        p_cnt    = DMA_count;
        p_read   = DMA_read;
        p_alu_en = ALU_en;
    end

    // Reference: per neuron one write and one block fetch, blocks packed
    // back-to-back per layer.
    function automatic void build_model();
        int base, a;
        exp_wr.delete();
        exp_fa.delete();
        base = 0;
        for (int l = 0; l < NL; l++) begin
            for (int n = 0; n < OUT_T[l]; n++) begin
                exp_wr.push_back({20'd0, 2'(l), 3'(l), 7'(n)});
                a = (base + n * (IN_T[l] + 1)) % 65536;
                exp_fa.push_back({3'd0, 16'(a), 7'(IN_T[l] + 1), 1'b1,
                                  1'(n != OUT_T[l] - 1), 2'b11, 2'd1});
            end
            base = (base + OUT_T[l] * (IN_T[l] + 1)) % 65536;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        obs_wr.delete();
        obs_fa.delete();
        obs_wc.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; clk_en = 1'b1; DMA_ready = 1'b0;
`ifdef FC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        tick();
        clear_mon();
    endtask

    // rdy_mode 0: random ready, 1: held high. en_mode 1: random clk_en.
    task automatic run_to_done(input int rdy_mode, input int en_mode, output bit ok);
        int budget = 20000;
        start = 1'b1;
        while (done !== 1'b1 && budget > 0) begin
            clk_en    = en_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            DMA_ready = rdy_mode != 0 ? 1'b1 : ($urandom_range(0, 2) == 0);
            tick();
            budget--;
        end
        clk_en = 1'b1;
        DMA_ready = 1'b0;
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs !== RST_VALS) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", outs, RST_VALS);
        end
        DMA_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (outs !== RST_VALS) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=%h", outs, RST_VALS);
        end
    endtask

    task automatic test_main();
        bit ok;
        do_reset();
        run_to_done(0, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL main_timeout done=%b exp=1", done); end
        checks++;
        if (Bus_datasrc !== 2'd2) begin
            failures++; $display("FAIL main_done_src got=%0d exp=2", Bus_datasrc);
        end
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_fa.size() != exp_fa.size()) begin
            failures++;
            $display("FAIL main_counts wr=%0d fa=%0d exp=%0d", obs_wr.size(), obs_fa.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++; $display("FAIL main_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]); break;
            end
        end
        for (int i = 0; i < exp_fa.size() && i < obs_fa.size(); i++) begin
            checks++;
            if (obs_fa[i] !== exp_fa[i]) begin
                failures++; $display("FAIL main_fetch[%0d] got=%h exp=%h", i, obs_fa[i], exp_fa[i]); break;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gap, eg;
        do_reset();
        run_to_done(1, 0, ok);
        checks++;
        if (!ok || obs_wr.size() != exp_wr.size() || obs_fa.size() != exp_fa.size()) begin
            failures++;
            $display("FAIL b2b_counts done=%b wr=%0d fa=%0d exp=%0d", done, obs_wr.size(), obs_fa.size(), exp_wr.size());
        end
        for (int i = 1; i < obs_wc.size() && i < exp_wr.size(); i++) begin
            gap = obs_wc[i] - obs_wc[i-1];
            eg  = (exp_wr[i][9:7] != exp_wr[i-1][9:7]) ? 5 : 3;
            checks++;
            if (gap != eg) begin
                failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, gap, eg); break;
            end
        end
        for (int i = 0; i < exp_fa.size() && i < obs_fa.size(); i++) begin
            checks++;
            if (obs_fa[i] !== exp_fa[i]) begin
                failures++; $display("FAIL b2b_fetch[%0d] got=%h exp=%h", i, obs_fa[i], exp_fa[i]); break;
            end
        end
    endtask

    task automatic test_clk_en();
        bit ok;
        do_reset();
        run_to_done(0, 1, ok);
        checks++;
        if (!ok || obs_wr.size() != exp_wr.size() || obs_fa.size() != exp_fa.size()) begin
            failures++;
            $display("FAIL clken_counts done=%b wr=%0d fa=%0d exp=%0d", done, obs_wr.size(), obs_fa.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++; $display("FAIL clken_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]); break;
            end
        end
        for (int i = 0; i < exp_fa.size() && i < obs_fa.size(); i++) begin
            checks++;
            if (obs_fa[i] !== exp_fa[i]) begin
                failures++; $display("FAIL clken_fetch[%0d] got=%h exp=%h", i, obs_fa[i], exp_fa[i]); break;
            end
        end
    endtask

    // Continues from DONE left by the previous test.
    task automatic test_done_restart();
        bit ok;
        start = 1'b1;
        repeat (4) tick();
        checks++;
        if (done !== 1'b1 || Bus_datasrc !== 2'd2) begin
            failures++; $display("FAIL done_held done=%b src=%0d exp=1/2", done, Bus_datasrc);
        end
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_after_drop got=%b exp=1", done); end
        clear_mon();
        start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || layer !== 3'd0) begin
            failures++; $display("FAIL restart_edge done=%b layer=%0d exp=0/0", done, layer);
        end
        run_to_done(0, 0, ok);
        checks++;
        if (!ok || obs_wr.size() != exp_wr.size() || obs_fa.size() != exp_fa.size()) begin
            failures++;
            $display("FAIL restart_counts done=%b wr=%0d fa=%0d exp=%0d", done, obs_wr.size(), obs_fa.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++; $display("FAIL restart_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]); break;
            end
        end
        for (int i = 0; i < exp_fa.size() && i < obs_fa.size(); i++) begin
            checks++;
            if (obs_fa[i] !== exp_fa[i]) begin
                failures++; $display("FAIL restart_fetch[%0d] got=%h exp=%h", i, obs_fa[i], exp_fa[i]); break;
            end
        end
    endtask

    task automatic test_mid_reset();
        int budget = 5000;
        do_reset();
        start = 1'b1;
        while (obs_wr.size() < 40 && budget > 0) begin
            DMA_ready = ($urandom_range(0, 2) == 0);
            tick();
            budget--;
        end
        checks++;
        if (obs_wr.size() != 40) begin
            failures++; $display("FAIL midrst_reach got=%0d exp=40", obs_wr.size());
        end
        rst = 1'b0; clk_en = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (outs !== RST_VALS) begin
            failures++; $display("FAIL midrst_values got=%h exp=%h", outs, RST_VALS);
        end
        rst = 1'b1; clk_en = 1'b1;
        repeat (2) tick();
        checks++;
        if (outs !== RST_VALS) begin
            failures++; $display("FAIL midrst_idle got=%h exp=%h", outs, RST_VALS);
        end
        clear_mon();
        start = 1'b1;
        budget = 200;
        while (obs_fa.size() < 1 && budget > 0) begin
            DMA_ready = ($urandom_range(0, 1) == 0);
            tick();
            budget--;
        end
        checks++;
        if (obs_fa.size() < 1 || obs_fa[0] !== exp_fa[0]) begin
            failures++;
            $display("FAIL midrst_first_fetch got=%h exp=%h", obs_fa.size() > 0 ? obs_fa[0] : 32'hx, exp_fa[0]);
        end
    endtask

`ifdef FC_ABORT_EN
    task automatic test_abort();
        int budget = 5000;
        do_reset();
        start = 1'b1;
        while (obs_wr.size() < 89 && budget > 0) begin
            DMA_ready = ($urandom_range(0, 2) == 0);
            tick();
            budget--;
        end
        abort = 1'b1; start = 1'b0; DMA_ready = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (outs !== RST_VALS) begin
            failures++; $display("FAIL abort_values got=%h exp=%h", outs, RST_VALS);
        end
        repeat (30) begin
            DMA_ready = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if (obs_wr.size() != 89 || done !== 1'b0 || Neuron_en !== 2'b11) begin
            failures++;
            $display("FAIL abort_quiet writes=%0d done=%b nen=%b exp=89/0/11", obs_wr.size(), done, Neuron_en);
        end
    endtask
`endif

    initial begin
        build_model();
        test_reset();
        test_main();
        test_back_to_back();
        test_clk_en();
        test_done_restart();
        test_mid_reset();
`ifdef FC_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
